// File: rtl/llc_mshr_pkg.sv
// Shared types and default widths for the LLC MSHR table.
// The set-conflict comparators in llc_mshr_table are built only when LLC_MSHR_SET_CONFLICT_EN is defined.
package llc_mshr_pkg;

  localparam int MSHR_N_ENTRIES_DEF = 4;
  localparam int LINE_ADDR_W_DEF    = 26;
  localparam int SET_W_DEF          = 9;
  localparam int WORDS_DEF          = 4;
  localparam int STATE_W_DEF        = 3;
  localparam int CNT_W_DEF          = 5;
  localparam int ID_W_DEF           = 4;

  // Unstable-state encoding shared with the LLC FSM.
  typedef enum logic [STATE_W_DEF-1:0] {
    UNST_NONE     = 3'd0,
    UNST_MEM_FILL = 3'd1,
    UNST_RECALL   = 3'd2,
    UNST_INV_WAIT = 3'd3,
    UNST_FWD_WAIT = 3'd4,
    UNST_EVICT    = 3'd5
  } unstable_state_t;

  typedef struct packed {
    logic                       valid;
    logic [LINE_ADDR_W_DEF-1:0] addr;
    logic [ID_W_DEF-1:0]        req_id;
    logic [STATE_W_DEF-1:0]     state;
    logic [CNT_W_DEF-1:0]       invack;
    logic [WORDS_DEF-1:0]       word_mask;
  } mshr_entry_t;

endpackage

// File: rtl/llc_mshr_table_prio_enc.sv
// Lowest-index priority encoder: idx is the lowest set bit of in_vec, 0 when none is set.
module llc_mshr_prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     in_vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  always_comb begin
    idx   = '0;
    found = |in_vec;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/llc_mshr_table.sv
// Configurable-depth MSHR table: allocate, associative lookup, update, retire and invack completion.
// Define LLC_MSHR_SET_CONFLICT_EN to build the set-index conflict comparators.
module llc_mshr_table
  import llc_mshr_pkg::*;
#(
  parameter int N_ENTRIES   = MSHR_N_ENTRIES_DEF,
  parameter int LINE_ADDR_W = LINE_ADDR_W_DEF,
  parameter int SET_W       = SET_W_DEF,
  parameter int WORDS       = WORDS_DEF,
  parameter int STATE_W     = STATE_W_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int ID_W        = ID_W_DEF,
  parameter int IDX_W       = $clog2(N_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   rst,
  // Allocation transfers on a cycle where alloc_valid && alloc_ready; alloc_ready
  // does not depend on alloc_valid, and alloc_idx names the slot that will be written.
  input  logic                   alloc_valid,
  output logic                   alloc_ready,
  input  logic [LINE_ADDR_W-1:0] alloc_addr,
  input  logic [ID_W-1:0]        alloc_req_id,
  input  logic [STATE_W-1:0]     alloc_state,
  input  logic [CNT_W-1:0]       alloc_invack,
  input  logic [WORDS-1:0]       alloc_word_mask,
  output logic [IDX_W-1:0]       alloc_idx,
  input  logic                   lookup_valid,
  input  logic [LINE_ADDR_W-1:0] lookup_addr,
  output logic                   lookup_rsp_valid,
  output logic                   lookup_hit,
  output logic                   lookup_set_conflict,
  output logic [IDX_W-1:0]       lookup_idx,
  input  logic                   upd_valid,
  input  logic [IDX_W-1:0]       upd_idx,
  input  logic [WORDS-1:0]       upd_word_mask,
  input  logic                   upd_invack_dec,
  input  logic                   upd_state_we,
  input  logic [STATE_W-1:0]     upd_state,
  input  logic                   retire_valid,
  input  logic [IDX_W-1:0]       retire_idx,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic                   rd_valid,
  output logic [LINE_ADDR_W-1:0] rd_addr,
  output logic [ID_W-1:0]        rd_req_id,
  output logic [STATE_W-1:0]     rd_state,
  output logic [CNT_W-1:0]       rd_invack,
  output logic [WORDS-1:0]       rd_word_mask,
  output logic                   invack_done,
  output logic [IDX_W-1:0]       invack_done_idx,
  output logic [IDX_W:0]         cnt,
  output logic                   full,
  output logic                   empty,
  output logic                   err
);

  typedef struct packed {
    logic                   valid;
    logic [LINE_ADDR_W-1:0] addr;
    logic [ID_W-1:0]        req_id;
    logic [STATE_W-1:0]     state;
    logic [CNT_W-1:0]       invack;
    logic [WORDS-1:0]       word_mask;
  } entry_t;

  entry_t tbl_q [N_ENTRIES];

  logic [N_ENTRIES-1:0] valid_vec, free_vec, hit_vec, conf_vec;
  logic [IDX_W-1:0]     hit_idx, conf_idx;
  logic                 free_found, hit_found, conf_found;
  logic [IDX_W:0]       cnt_q, cnt_next;
  logic                 full_q, empty_q, err_q;
  logic                 alloc_fire, upd_ok, retire_ok, upd_retired;
  logic                 done_next, err_event;
  logic [CNT_W-1:0]     cur_invack;

  always_comb begin
    for (int i = 0; i < N_ENTRIES; i++) begin
      valid_vec[i] = tbl_q[i].valid;
      hit_vec[i]   = tbl_q[i].valid && (tbl_q[i].addr == lookup_addr);
`ifdef LLC_MSHR_SET_CONFLICT_EN
      conf_vec[i]  = tbl_q[i].valid && (tbl_q[i].addr[SET_W-1:0] == lookup_addr[SET_W-1:0]);
`else
      conf_vec[i]  = 1'b0;
`endif
    end
    free_vec = ~valid_vec;
  end

  llc_mshr_prio_enc #(.N(N_ENTRIES), .IDX_W(IDX_W)) u_free_enc (
    .in_vec(free_vec), .idx(alloc_idx), .found(free_found)
  );
  llc_mshr_prio_enc #(.N(N_ENTRIES), .IDX_W(IDX_W)) u_hit_enc (
    .in_vec(hit_vec), .idx(hit_idx), .found(hit_found)
  );
  llc_mshr_prio_enc #(.N(N_ENTRIES), .IDX_W(IDX_W)) u_conf_enc (
    .in_vec(conf_vec), .idx(conf_idx), .found(conf_found)
  );

  assign alloc_ready = !full_q;
  assign alloc_fire  = alloc_valid && alloc_ready && free_found;
  assign upd_ok      = upd_valid && valid_vec[upd_idx];
  assign retire_ok   = retire_valid && valid_vec[retire_idx];
  assign upd_retired = retire_valid && (retire_idx == upd_idx);
  assign cur_invack  = tbl_q[upd_idx].invack;

  // A retire to the same slot wins over the update, so its completion is dropped.
  assign done_next = upd_ok && upd_invack_dec && (cur_invack == CNT_W'(1)) && !upd_retired;
  assign err_event = (upd_valid && !valid_vec[upd_idx])
                  || (upd_ok && upd_invack_dec && (cur_invack == '0))
                  || (retire_valid && !valid_vec[retire_idx]);

  always_comb begin
    cnt_next = cnt_q;
    if (alloc_fire && !retire_ok)      cnt_next = cnt_q + (IDX_W+1)'(1);
    else if (!alloc_fire && retire_ok) cnt_next = cnt_q - (IDX_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_ENTRIES; i++) tbl_q[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        if (alloc_fire && (alloc_idx == IDX_W'(i))) begin
          tbl_q[i].valid     <= 1'b1;
          tbl_q[i].addr      <= alloc_addr;
          tbl_q[i].req_id    <= alloc_req_id;
          tbl_q[i].state     <= alloc_state;
          tbl_q[i].invack    <= alloc_invack;
          tbl_q[i].word_mask <= alloc_word_mask;
        end else begin
          if (upd_ok && (upd_idx == IDX_W'(i))) begin
            tbl_q[i].word_mask <= tbl_q[i].word_mask | upd_word_mask;
            if (upd_state_we) tbl_q[i].state <= upd_state;
            if (upd_invack_dec && (tbl_q[i].invack != '0))
              tbl_q[i].invack <= tbl_q[i].invack - CNT_W'(1);
          end
          if (retire_ok && (retire_idx == IDX_W'(i))) tbl_q[i].valid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q               <= '0;
      full_q              <= 1'b0;
      empty_q             <= 1'b1;
      err_q               <= 1'b0;
      invack_done         <= 1'b0;
      invack_done_idx     <= '0;
      lookup_rsp_valid    <= 1'b0;
      lookup_hit          <= 1'b0;
      lookup_set_conflict <= 1'b0;
      lookup_idx          <= '0;
    end else begin
      cnt_q            <= cnt_next;
      full_q           <= (cnt_next == (IDX_W+1)'(N_ENTRIES));
      empty_q          <= (cnt_next == '0);
      err_q            <= err_q || err_event;
      invack_done      <= done_next;
      if (done_next) invack_done_idx <= upd_idx;
      lookup_rsp_valid <= lookup_valid;
      if (lookup_valid) begin
        lookup_hit          <= hit_found;
        lookup_set_conflict <= conf_found;
        lookup_idx          <= hit_found ? hit_idx : (conf_found ? conf_idx : '0);
      end
    end
  end

  assign cnt   = cnt_q;
  assign full  = full_q;
  assign empty = empty_q;
  assign err   = err_q;

  assign rd_valid     = tbl_q[rd_idx].valid;
  assign rd_addr      = tbl_q[rd_idx].addr;
  assign rd_req_id    = tbl_q[rd_idx].req_id;
  assign rd_state     = tbl_q[rd_idx].state;
  assign rd_invack    = tbl_q[rd_idx].invack;
  assign rd_word_mask = tbl_q[rd_idx].word_mask;

endmodule

// File: tb/tb_llc_mshr_table.sv
// Directed bench for llc_mshr_table; lookup responses and invack completions go through expected queues.
module tb_llc_mshr_table;
  import llc_mshr_pkg::*;

  localparam int AW = 26, IW = 4, STW = 3, CW = 5, WD = 4, XW = 2;
`ifdef LLC_MSHR_SET_CONFLICT_EN
  localparam logic CONF_EN = 1'b1;
`else
  localparam logic CONF_EN = 1'b0;
`endif

  logic clk, rst;
  logic alloc_valid, alloc_ready;
  logic [AW-1:0] alloc_addr;
  logic [IW-1:0] alloc_req_id;
  logic [STW-1:0] alloc_state;
  logic [CW-1:0] alloc_invack;
  logic [WD-1:0] alloc_word_mask;
  logic [XW-1:0] alloc_idx;
  logic lookup_valid, lookup_rsp_valid, lookup_hit, lookup_set_conflict;
  logic [AW-1:0] lookup_addr;
  logic [XW-1:0] lookup_idx;
  logic upd_valid, upd_invack_dec, upd_state_we;
  logic [XW-1:0] upd_idx;
  logic [WD-1:0] upd_word_mask;
  logic [STW-1:0] upd_state;
  logic retire_valid;
  logic [XW-1:0] retire_idx, rd_idx;
  logic rd_valid;
  logic [AW-1:0] rd_addr;
  logic [IW-1:0] rd_req_id;
  logic [STW-1:0] rd_state;
  logic [CW-1:0] rd_invack;
  logic [WD-1:0] rd_word_mask;
  logic invack_done;
  logic [XW-1:0] invack_done_idx;
  logic [XW:0] cnt;
  logic full, empty, err;

  logic [XW+1:0] exp_q[$];
  logic [XW-1:0] done_q[$];
  int n_vec = 0;
  int n_err = 0;

  llc_mshr_table dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_addr(alloc_addr),
    .alloc_req_id(alloc_req_id), .alloc_state(alloc_state), .alloc_invack(alloc_invack),
    .alloc_word_mask(alloc_word_mask), .alloc_idx(alloc_idx),
    .lookup_valid(lookup_valid), .lookup_addr(lookup_addr), .lookup_rsp_valid(lookup_rsp_valid),
    .lookup_hit(lookup_hit), .lookup_set_conflict(lookup_set_conflict), .lookup_idx(lookup_idx),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_word_mask(upd_word_mask),
    .upd_invack_dec(upd_invack_dec), .upd_state_we(upd_state_we), .upd_state(upd_state),
    .retire_valid(retire_valid), .retire_idx(retire_idx),
    .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_req_id(rd_req_id),
    .rd_state(rd_state), .rd_invack(rd_invack), .rd_word_mask(rd_word_mask),
    .invack_done(invack_done), .invack_done_idx(invack_done_idx),
    .cnt(cnt), .full(full), .empty(empty), .err(err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver tasks; the cursor always sits on a falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    alloc_valid = 0; alloc_addr = '0; alloc_req_id = '0; alloc_state = '0;
    alloc_invack = '0; alloc_word_mask = '0;
    lookup_valid = 0; lookup_addr = '0;
    upd_valid = 0; upd_idx = '0; upd_word_mask = '0; upd_invack_dec = 0;
    upd_state_we = 0; upd_state = '0;
    retire_valid = 0; retire_idx = '0;
  endtask

  task automatic alloc(input logic [AW-1:0] a, input logic [IW-1:0] id, input logic [STW-1:0] st,
                       input logic [CW-1:0] inv, input logic [WD-1:0] m, input logic [XW-1:0] exp_idx);
    check("alloc_idx", 32'(alloc_idx), 32'(exp_idx));
    check("alloc_ready", 32'(alloc_ready), 32'd1);
    alloc_valid = 1; alloc_addr = a; alloc_req_id = id; alloc_state = st;
    alloc_invack = inv; alloc_word_mask = m;
    step();
    alloc_valid = 0;
  endtask

  task automatic lookup(input logic [AW-1:0] a, input logic h, input logic c, input logic [XW-1:0] i);
    lookup_valid = 1; lookup_addr = a;
    exp_q.push_back({h, c, i});
    step();
    lookup_valid = 0;
  endtask

  task automatic upd(input logic [XW-1:0] i, input logic [WD-1:0] m, input logic dec,
                     input logic we, input logic [STW-1:0] st);
    upd_valid = 1; upd_idx = i; upd_word_mask = m; upd_invack_dec = dec;
    upd_state_we = we; upd_state = st;
    step();
    upd_valid = 0; upd_invack_dec = 0; upd_state_we = 0; upd_word_mask = '0;
  endtask

  task automatic retire(input logic [XW-1:0] i);
    retire_valid = 1; retire_idx = i;
    step();
    retire_valid = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cnt"}, 32'(cnt), 32'd0);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_full"}, 32'(full), 32'd0);
    check({tag, "_alloc_ready"}, 32'(alloc_ready), 32'd1);
    check({tag, "_alloc_idx"}, 32'(alloc_idx), 32'd0);
    check({tag, "_rsp_valid"}, 32'(lookup_rsp_valid), 32'd0);
    check({tag, "_hit"}, 32'(lookup_hit), 32'd0);
    check({tag, "_conflict"}, 32'(lookup_set_conflict), 32'd0);
    check({tag, "_lookup_idx"}, 32'(lookup_idx), 32'd0);
    check({tag, "_invack_done"}, 32'(invack_done), 32'd0);
    check({tag, "_done_idx"}, 32'(invack_done_idx), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic check_rd(input string name, input logic [XW-1:0] i, input logic v);
    rd_idx = i;
    #1;
    check(name, 32'(rd_valid), 32'(v));
  endtask

  // Scoreboard monitor
  initial begin
    logic [XW+1:0] e;
    logic [XW-1:0] d;
    forever begin
      @(negedge clk);
      if (lookup_rsp_valid) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL lookup_rsp_unexpected: got {hit,conf,idx}=0x%0h expected none",
                   {lookup_hit, lookup_set_conflict, lookup_idx});
        end else begin
          e = exp_q.pop_front();
          if ({lookup_hit, lookup_set_conflict, lookup_idx} !== e) begin
            n_err++;
            $display("FAIL lookup_rsp: got {hit,conf,idx}=0x%0h expected 0x%0h",
                     {lookup_hit, lookup_set_conflict, lookup_idx}, e);
          end
        end
      end
      if (invack_done) begin
        n_vec++;
        if (done_q.size() == 0) begin
          n_err++;
          $display("FAIL invack_done_unexpected: got idx %0d expected no pulse", invack_done_idx);
        end else begin
          d = done_q.pop_front();
          if (invack_done_idx !== d) begin
            n_err++;
            $display("FAIL invack_done_idx: got %0d expected %0d", invack_done_idx, d);
          end
        end
      end
    end
  end

  initial begin
    idle();
    rd_idx = '0;
    rst = 1;
    step(); step();
    rst = 0;
    check_reset_vals("reset");

    // Fill the table back to back
    for (int i = 0; i < 4; i++)
      alloc(AW'(32'h100 + i), IW'(i), UNST_MEM_FILL, '0, '0, XW'(i));
    check("fill_cnt", 32'(cnt), 32'd4);
    check("fill_full", 32'(full), 32'd1);
    check("fill_alloc_ready", 32'(alloc_ready), 32'd0);
    check("fill_empty", 32'(empty), 32'd0);
    check_rd("fill_rd_valid", 2'd2, 1'b1);
    check("fill_rd_addr", 32'(rd_addr), 32'h102);
    check("fill_rd_req_id", 32'(rd_req_id), 32'd2);
    lookup(AW'(32'h101), 1'b1, CONF_EN, 2'd1);
    lookup(AW'(32'h3FF), 1'b0, 1'b0, 2'd0);

    // Retire and alloc together while full: the alloc is refused
    retire_valid = 1; retire_idx = 2'd2;
    alloc_valid = 1; alloc_addr = AW'(32'h1AA);
    step();
    idle();
    check("rr_cnt", 32'(cnt), 32'd3);
    check("rr_full", 32'(full), 32'd0);
    check_rd("rr_rd_valid", 2'd2, 1'b0);
    alloc(AW'(32'h1AB), 4'd9, UNST_RECALL, '0, '0, 2'd2);
    check("rr_cnt_back", 32'(cnt), 32'd4);
    check_rd("rr_slot2_valid", 2'd2, 1'b1);
    check("rr_slot2_addr", 32'(rd_addr), 32'h1AB);
    for (int i = 0; i < 4; i++) retire(XW'(i));
    check("drain_cnt", 32'(cnt), 32'd0);
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_err", 32'(err), 32'd0);

    // Hit and set-conflict lookups
    alloc(AW'(32'h2A5), 4'd1, UNST_RECALL, '0, '0, 2'd0);
    alloc(AW'(32'h3C7), 4'd2, UNST_RECALL, '0, '0, 2'd1);
    lookup(AW'(32'h2A5), 1'b1, CONF_EN, 2'd0);
    lookup(AW'(32'h4A5), 1'b0, CONF_EN, 2'd0);
    lookup(AW'(32'h5C7), 1'b0, CONF_EN, CONF_EN ? 2'd1 : 2'd0);

    // Lookup in the same cycle as the alloc sees the pre-edge table
    check("la_alloc_idx", 32'(alloc_idx), 32'd2);
    alloc_valid = 1; alloc_addr = AW'(32'h777);
    lookup_valid = 1; lookup_addr = AW'(32'h777);
    exp_q.push_back({1'b0, 1'b0, 2'd0});
    step();
    idle();
    lookup(AW'(32'h777), 1'b1, CONF_EN, 2'd2);

    // Invack collection, completion and underflow
    alloc(AW'(32'h155), 4'd3, UNST_INV_WAIT, 5'd2, 4'b0001, 2'd3);
    upd(2'd3, 4'b0000, 1'b1, 1'b0, '0);
    rd_idx = 2'd3; #1;
    check("inv_first_dec", 32'(rd_invack), 32'd1);
    done_q.push_back(2'd3);
    upd(2'd3, 4'b0100, 1'b1, 1'b1, UNST_FWD_WAIT);
    check("inv_second_dec", 32'(rd_invack), 32'd0);
    check("inv_state", 32'(rd_state), 32'(UNST_FWD_WAIT));
    check("inv_mask", 32'(rd_word_mask), 32'b0101);
    check("inv_err_before", 32'(err), 32'd0);
    upd(2'd3, 4'b0000, 1'b1, 1'b0, '0);
    check("inv_underflow_err", 32'(err), 32'd1);
    check("inv_saturate", 32'(rd_invack), 32'd0);
    check("inv_still_valid", 32'(rd_valid), 32'd1);

    // Update and retire of the same entry: retire wins, no completion
    retire(2'd0);
    alloc(AW'(32'h0AA), 4'd4, UNST_INV_WAIT, 5'd1, '0, 2'd0);
    upd_valid = 1; upd_idx = 2'd0; upd_invack_dec = 1;
    retire_valid = 1; retire_idx = 2'd0;
    step();
    idle();
    check("ur_no_done", 32'(invack_done), 32'd0);
    check_rd("ur_invalid", 2'd0, 1'b0);
    check("ur_cnt", 32'(cnt), 32'd3);

    // Reset in the middle of traffic, with a completion pending
    alloc(AW'(32'h0BB), 4'd5, UNST_INV_WAIT, 5'd1, '0, 2'd0);
    check("mid_full", 32'(full), 32'd1);
    rst = 1;
    upd_valid = 1; upd_idx = 2'd0; upd_invack_dec = 1;
    lookup_valid = 1; lookup_addr = AW'(32'h0BB);
    alloc_valid = 1; alloc_addr = AW'(32'h0CC);
    step();
    rst = 0;
    idle();
    check_reset_vals("midrst");
    check_rd("midrst_rd_valid", 2'd0, 1'b0);

    step(); step();
    #1;
    check("lookup_queue_drained", 32'(exp_q.size()), 32'd0);
    check("done_queue_drained", 32'(done_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
